multicycle_control: RTL

//   Sequencing FSM for the multi-cycle variant of the 16-bit MIPS datapath with its 4-entry register file.

---
 rtl/multicycle_control_if.sv | 35 +++
 rtl/multicycle_control.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - controller <-> datapath bus: opcode/memory handshake in, per-cycle strobes out
interface multicycle_control_if;
    logic [3:0]  opcode;
    logic        mem_ready;
    logic [15:0] pc_inc;
    logic        pc_write;
    logic        pc_write_cond;
    logic        pc_source;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic        instr_done;
    logic        halted;

    modport master (
        input  opcode, mem_ready,
        output pc_inc, pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               instr_done, halted
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_inc, pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               instr_done, halted
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle 16-bit MIPS sequencing FSM; MC_CTRL_PERF_EN adds cycle/instruction counters
module multicycle_control #(
    parameter int PC_INC = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    multicycle_control_if.master bus
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [15:0]          cycle_count,
    output logic [15:0]          instr_count
`endif
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_RWB    = 4'd3,
        S_ADDIEX = 4'd4,
        S_IWB    = 4'd5,
        S_MEMADR = 4'd6,
        S_MEMRD  = 4'd7,
        S_MEMWB  = 4'd8,
        S_MEMWR  = 4'd9,
        S_BRANCH = 4'd10,
        S_HALT   = 4'd11
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SW   = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;

    state_t     state;
    state_t     state_next;
    logic [3:0] op_q;

    function automatic logic [2:0] alu_ctl(input logic [3:0] op);
        case (op)
            OP_SUB:  return 3'b110;
            OP_AND:  return 3'b000;
            OP_OR:   return 3'b001;
            OP_SLT:  return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    assign bus.pc_inc = 16'(PC_INC);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= S_FETCH;
            op_q  <= 4'b0000;
        end else begin
            state <= state_next;
            if (state == S_DECODE)
                op_q <= bus.opcode;
        end
    end

    // DECODE steers on the live opcode; later states only see the registered copy.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (bus.mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: state_next = S_EXEC;
                    OP_LW, OP_SW:                          state_next = S_MEMADR;
                    OP_ADDI:                               state_next = S_ADDIEX;
                    OP_BEQ:                                state_next = S_BRANCH;
                    default:                               state_next = S_HALT;
                endcase
            end
            S_EXEC:   state_next = S_RWB;
            S_RWB:    state_next = S_FETCH;
            S_ADDIEX: state_next = S_IWB;
            S_IWB:    state_next = S_FETCH;
            S_MEMADR: state_next = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) state_next = S_MEMWB;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  if (bus.mem_ready) state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    // Strobes are suppressed while reset_n is low so an abandoned instruction commits nothing.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_source     = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 3'b010;
        bus.instr_done    = 1'b0;
        bus.halted        = 1'b0;
        if (reset_n) begin
            case (state)
                S_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = 2'b01;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                    end
                end
                S_DECODE: bus.alu_src_b = 2'b11;
                S_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = alu_ctl(op_q);
                end
                S_RWB: begin
                    bus.reg_dst    = 1'b1;
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_ADDIEX, S_MEMADR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                end
                S_IWB: begin
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_MEMRD: begin
                    bus.i_or_d   = 1'b1;
                    bus.mem_read = 1'b1;
                end
                S_MEMWB: begin
                    bus.mem_to_reg = 1'b1;
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_MEMWR: begin
                    bus.i_or_d     = 1'b1;
                    bus.mem_write  = 1'b1;
                    bus.instr_done = bus.mem_ready;
                end
                S_BRANCH: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_op        = 3'b110;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_source     = 1'b1;
                    bus.instr_done    = 1'b1;
                end
                S_HALT:  bus.halted = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MC_CTRL_PERF_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cycle_count <= 16'h0000;
            instr_count <= 16'h0000;
        end else begin
            if (state != S_HALT)
                cycle_count <= cycle_count + 16'h0001;
            if (bus.instr_done)
                instr_count <= instr_count + 16'h0001;
        end
    end
`endif

endmodule
